// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared types for the R-channel reorder path (order entries,
//               ordering FSM states, default sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    localparam int ID_WIDTH = 4;
    localparam int NUM_UIDS = 16;

    typedef struct packed {
        logic [ID_WIDTH-1:0] uid;
        logic [ID_WIDTH-1:0] orig_id;
    } order_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } ord_state_e;

endpackage
`default_nettype wire

// File: rtl/rob_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rob_order_fifo
// Description : Synchronous FIFO of packed order entries with full/empty/count.
//               DEPTH must be a power of two and at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_order_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    import rob_pkg::*;

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wptr;
    logic [c_AW:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign o_count = r_wptr - r_rptr;
    assign o_head  = r_mem[r_rptr[c_AW-1:0]];

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_AW-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/r_ordering_unit.sv
`default_nettype none
// ============================================================================
// Module      : r_ordering_unit
// Description : Releases buffered R bursts in AR-issue order, restoring the
//               master's original ID and returning each UID after its last beat.
// Revision    : 1.0 - initial release
// ============================================================================
module r_ordering_unit #(
    parameter int NUM_UIDS   = rob_pkg::NUM_UIDS,
    parameter int MAX_BEATS  = 8,
    parameter int ID_WIDTH   = rob_pkg::ID_WIDTH,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [ID_WIDTH-1:0]     alloc_uid,
    input  logic [ID_WIDTH-1:0]     alloc_orig_id,
    output logic [ID_WIDTH-1:0]     uid_to_free,
    input  logic                    rm_in_valid,
    output logic                    rm_in_ready,
    input  logic [ID_WIDTH-1:0]     rm_in_id,
    input  logic [DATA_WIDTH-1:0]   rm_in_data,
    input  logic [RESP_WIDTH-1:0]   rm_in_resp,
    input  logic                    rm_in_last,
    output logic                    r_release_valid,
    input  logic                    r_release_ready,
    output logic [ID_WIDTH-1:0]     r_release_id,
    output logic [DATA_WIDTH-1:0]   r_release_data,
    output logic [RESP_WIDTH-1:0]   r_release_resp,
    output logic                    r_release_last,
    output logic                    uid_rel_valid,
    output logic [ID_WIDTH-1:0]     uid_rel,
    output logic                    err_overflow
);
    import rob_pkg::*;

    localparam int c_AW   = $clog2(NUM_UIDS);
    localparam int c_BC_W = $clog2(MAX_BEATS + 1) + 1;
    localparam logic [c_BC_W-1:0] c_MAX_BEATS = c_BC_W'(MAX_BEATS);

    order_entry_t       w_push_entry;
    order_entry_t       w_head;
    logic               w_full;
    logic               w_empty;
    logic [c_AW:0]      w_count;
    logic [c_AW:0]      w_count_after;
    logic               w_push;
    logic               w_xfer;
    logic               w_pop;
    logic               w_unused_id;

    ord_state_e         r_state;
    ord_state_e         w_state_nxt;
    logic [c_BC_W-1:0]  r_beat_cnt;
    logic               r_err;
    logic               r_uid_rel_valid;
    logic [ID_WIDTH-1:0] r_uid_rel;

    // The incoming beat ID is always replaced by the head entry's orig_id.
    assign w_unused_id   = ^rm_in_id;

    assign w_push_entry  = '{uid: alloc_uid, orig_id: alloc_orig_id};
    assign w_push        = alloc_valid & alloc_ready;
    assign w_xfer        = r_release_valid & r_release_ready;
    assign w_pop         = w_xfer & rm_in_last;

    rob_order_fifo #(
        .WIDTH (ID_WIDTH * 2),
        .DEPTH (NUM_UIDS)
    ) u_order_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign alloc_ready     = ~w_full;
    assign uid_to_free     = w_empty ? '0 : w_head.uid;
    assign r_release_valid = ~w_empty & rm_in_valid;
    assign rm_in_ready     = ~w_empty & r_release_ready;
    assign r_release_id    = w_empty ? '0 : w_head.orig_id;
    assign r_release_data  = w_empty ? '0 : rm_in_data;
    assign r_release_resp  = w_empty ? '0 : rm_in_resp;
    assign r_release_last  = ~w_empty & rm_in_last;

    assign uid_rel_valid   = r_uid_rel_valid;
    assign uid_rel         = r_uid_rel;
    assign err_overflow    = r_err;

    // Pop implies count >= 1, so this cannot underflow.
    assign w_count_after   = w_count - (c_AW+1)'(w_pop) + (c_AW+1)'(w_push);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_push) w_state_nxt = WAIT;
            WAIT: begin
                if (w_pop)       w_state_nxt = (w_count_after == '0) ? IDLE : WAIT;
                else if (w_xfer) w_state_nxt = STREAM;
            end
            STREAM:  if (w_pop) w_state_nxt = (w_count_after == '0) ? IDLE : WAIT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt      <= '0;
            r_err           <= 1'b0;
            r_uid_rel_valid <= 1'b0;
            r_uid_rel       <= '0;
        end else begin
            r_uid_rel_valid <= w_pop;
            if (w_pop) r_uid_rel <= w_head.uid;
            if (w_xfer) begin
                if (r_beat_cnt == c_MAX_BEATS) r_err <= 1'b1;
                // Saturate so a runaway burst cannot wrap back into range.
                if (rm_in_last)                     r_beat_cnt <= '0;
                else if (r_beat_cnt <= c_MAX_BEATS) r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
